// File: rtl/ls_pkg.sv
// Shared types, defaults and Latin-square entry helper for the AONT encoder.
package ls_pkg;

   localparam int LSLEN_DEF    = 16;
   localparam int LSLENLOG_DEF = 4;
   localparam int LS_MAXLEN    = 256;
   localparam int LS_MAXLOG    = 8;
   localparam int LS_IDXW      = $clog2(LS_MAXLEN * LS_MAXLOG);

   typedef logic [LSLENLOG_DEF-1:0]         sym_t;
   typedef logic [LS_MAXLOG-1:0]            wsym_t;
   typedef logic [LS_MAXLEN*LS_MAXLOG-1:0]  wkey_t;

   typedef enum logic [2:0] {IDLE, CHECK, READY, ENC, TAG} ls_state_e;

   // L[r][x] = (key[x] + r) mod 2^lslog; key is zero-extended to the widest supported order.
   function automatic wsym_t ls_entry(input wkey_t key, input wsym_t r, input wsym_t x,
                                      input int unsigned lslog);
      wsym_t               k;
      wsym_t               mask;
      int unsigned         pos;
      logic [LS_IDXW-1:0]  idx;
      k = '0;
      for (int b = 0; b < LS_MAXLOG; b++) begin
         pos = int'(x) * lslog + b;
         idx = LS_IDXW'(pos);
         if (b < lslog) k[b] = key[idx];
      end
      mask = wsym_t'((32'd1 << lslog) - 32'd1);
      return (k + r) & mask;
   endfunction

endpackage

// File: rtl/ls_perm_check.sv
// Sequential permutation check: one key entry per cycle into a seen mask; done/ok are
// combinational on the final entry so the verdict lands LSLEN edges after start. No backpressure.
module ls_perm_check
   import ls_pkg::*;
#(
   parameter int LSLEN    = LSLEN_DEF,
   parameter int LSLENLOG = LSLENLOG_DEF
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic [LSLENLOG-1:0] entry,
   output logic [LSLENLOG-1:0] idx,
   output logic                done,
   output logic                ok
);

   localparam logic [LSLENLOG-1:0] CNT_LAST = LSLENLOG'(LSLEN - 1);

   logic                active;
   logic                dup;
   logic [LSLEN-1:0]    seen;
   logic [LSLENLOG-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         active <= 1'b0;
         dup    <= 1'b0;
         seen   <= '0;
         cnt    <= '0;
      end else if (start) begin
         active <= 1'b1;
         dup    <= 1'b0;
         seen   <= '0;
         cnt    <= '0;
      end else if (active) begin
         seen[entry] <= 1'b1;
         dup         <= dup | seen[entry];
         cnt         <= cnt + 1'b1;
         if (cnt == CNT_LAST) active <= 1'b0;
      end
   end

   assign idx  = cnt;
   assign done = active && (cnt == CNT_LAST);
   assign ok   = !dup && !seen[entry];

endmodule

// File: rtl/latin_aont_enc.sv
// Cyclic Latin-square AONT encoder: substitutes NOOFBLOCKS blocks, then appends a tag block.
// Latency 1 cycle in->out; single output register holds under stall and s_ready follows m_ready.
module latin_aont_enc
   import ls_pkg::*;
#(
   parameter int LSLEN      = LSLEN_DEF,
   parameter int LSLENLOG   = LSLENLOG_DEF,
   parameter int NOOFBLOCKS = 9
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      key_load,
   input  logic [LSLEN*LSLENLOG-1:0] key_row,
   output logic                      key_ready,
   output logic                      key_err,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [LSLENLOG-1:0]       s_sym,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [LSLENLOG-1:0]       m_sym,
   output logic                      m_tag,
   output logic                      m_last,
   output logic                      busy
);

   localparam int KW  = LSLEN * LSLENLOG;
   localparam int KIW = $clog2(KW);
   localparam logic [LSLENLOG-1:0] COL_LAST = LSLENLOG'(LSLEN - 1);
   localparam logic [LSLENLOG-1:0] BLK_LAST = LSLENLOG'(NOOFBLOCKS - 1);

   ls_state_e           state, state_nxt;
   logic [KW-1:0]       key_r;
   logic [LSLENLOG-1:0] blk, col;
   logic [LSLENLOG-1:0] acc [LSLEN];

   logic                key_start, chk_done, chk_ok;
   logic [LSLENLOG-1:0] chk_idx, chk_entry;
   logic [KIW-1:0]      chk_base, col_base;
   logic                s_fire, enc_last, tag_load, tag_fin;
   logic [LSLENLOG-1:0] c_sym, t_sym;

   assign key_start = key_load && (state == IDLE || state == READY);
   assign s_ready   = (state == ENC) && (!m_valid || m_ready);
   assign s_fire    = s_valid && s_ready;
   assign enc_last  = (blk == BLK_LAST) && (col == COL_LAST);
   assign tag_fin   = (state == TAG) && m_valid && m_ready && m_last;
   // Once the final tag symbol sits in the output register, stop loading and wait for its handshake.
   assign tag_load  = (state == TAG) && !(m_valid && m_last) && (!m_valid || m_ready);
   assign busy      = (state == CHECK) || (state == ENC) || (state == TAG);

   assign chk_base  = KIW'(chk_idx) * KIW'(LSLENLOG);
   assign col_base  = KIW'(col) * KIW'(LSLENLOG);
   assign chk_entry = key_r[chk_base +: LSLENLOG];
   assign c_sym     = LSLENLOG'(ls_entry(wkey_t'(key_r), wsym_t'(blk), wsym_t'(s_sym), LSLENLOG));
   assign t_sym     = acc[col] ^ key_r[col_base +: LSLENLOG];

   ls_perm_check #(
      .LSLEN    (LSLEN),
      .LSLENLOG (LSLENLOG)
   ) u_perm_check (
      .clk   (clk),
      .rstn  (rstn),
      .start (key_start),
      .entry (chk_entry),
      .idx   (chk_idx),
      .done  (chk_done),
      .ok    (chk_ok)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (key_load) state_nxt = CHECK;
         CHECK:   if (chk_done) state_nxt = chk_ok ? READY : IDLE;
         READY: begin
            if (key_load)     state_nxt = CHECK;
            else if (s_valid) state_nxt = ENC;
         end
         ENC:     if (s_fire && enc_last) state_nxt = TAG;
         TAG:     if (tag_fin) state_nxt = READY;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         key_r     <= '0;
         key_ready <= 1'b0;
         key_err   <= 1'b0;
         blk       <= '0;
         col       <= '0;
         m_valid   <= 1'b0;
         m_sym     <= '0;
         m_tag     <= 1'b0;
         m_last    <= 1'b0;
         for (int i = 0; i < LSLEN; i++) acc[i] <= '0;
      end else begin
         if (key_start) begin
            key_r     <= key_row;
            key_ready <= 1'b0;
            key_err   <= 1'b0;
         end
         if (state == CHECK && chk_done) begin
            key_ready <= chk_ok;
            key_err   <= !chk_ok;
         end
         if (s_fire) begin
            acc[col] <= acc[col] ^ c_sym;
            m_valid  <= 1'b1;
            m_sym    <= c_sym;
            m_tag    <= 1'b0;
            m_last   <= 1'b0;
            col      <= col + 1'b1;
            if (col == COL_LAST) blk <= enc_last ? '0 : blk + 1'b1;
         end else if (tag_load) begin
            m_valid <= 1'b1;
            m_sym   <= t_sym;
            m_tag   <= 1'b1;
            m_last  <= (col == COL_LAST);
            col     <= col + 1'b1;
         end else if (tag_fin) begin
            m_valid <= 1'b0;
            m_tag   <= 1'b0;
            m_last  <= 1'b0;
            blk     <= '0;
            col     <= '0;
            for (int i = 0; i < LSLEN; i++) acc[i] <= '0;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_latin_aont_enc.sv
// Directed bench for latin_aont_enc: hand-computed vectors plus a small reference model.
module tb_latin_aont_enc;

   localparam int L    = 16;
   localparam int LG   = 4;
   localparam int NB   = 9;
   localparam int NMSG = L * NB;

   logic            clk = 1'b0;
   logic            rstn;
   logic            key_load;
   logic [L*LG-1:0] key_row;
   logic            key_ready, key_err;
   logic            s_valid, s_ready;
   logic [LG-1:0]   s_sym;
   logic            m_valid, m_ready;
   logic [LG-1:0]   m_sym;
   logic            m_tag, m_last, busy;

   always #5 clk = ~clk;

   latin_aont_enc #(.LSLEN(L), .LSLENLOG(LG), .NOOFBLOCKS(NB)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .key_load  (key_load),
      .key_row   (key_row),
      .key_ready (key_ready),
      .key_err   (key_err),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_sym     (s_sym),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_sym     (m_sym),
      .m_tag     (m_tag),
      .m_last    (m_last),
      .busy      (busy)
   );

   int            total = 0;
   int            bad   = 0;
   logic [LG-1:0] msg [NMSG];
   logic [5:0]    outq [$];
   int            kv [L];
   int            s_cnt = 0;
   bit            last_seen = 0;
   bit            abort = 0;
   bit            rnd_rdy = 0;
   bit            prev_stall = 0;
   logic [LG-1:0] prev_sym = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [L*LG-1:0] pack_key();
      logic [L*LG-1:0] k;
      k = '0;
      for (int x = 0; x < L; x++) k[x*LG +: LG] = LG'(kv[x]);
      return k;
   endfunction

   // Output/input handshake monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) check("stall_hold", 32'({m_valid, m_sym}), 32'({1'b1, prev_sym}));
         if (m_valid && m_ready) begin
            outq.push_back({m_tag, m_last, m_sym});
            if (m_last) last_seen = 1;
         end
         if (s_valid && s_ready) s_cnt++;
         prev_stall = m_valid && !m_ready;
         prev_sym   = m_sym;
      end
   end

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic load_key(input bit exp_ok);
      key_row  = pack_key();
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      for (int i = 1; i <= L; i++) begin
         tick();
         if (i == 1)     check("busy_check", 32'(busy), 32'd1);
         if (i == L - 1) check("key_early", 32'(key_ready | key_err), 32'd0);
      end
      check("key_ready", 32'(key_ready), 32'(exp_ok));
      check("key_err", 32'(key_err), 32'(!exp_ok));
   endtask

   task automatic send_msg();
      bit ok;
      int n;
      for (int i = 0; i < NMSG; i++) begin
         s_valid = 1'b1;
         s_sym   = msg[i];
         n = 0;
         do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            n++;
         end while (!ok && n < 100 && !abort);
         if (abort) break;
         check("accept", 32'(ok), 32'd1);
         if (!ok) break;
      end
      s_valid = 1'b0;
   endtask

   task automatic run_msg();
      outq.delete();
      last_seen = 0;
      s_cnt = 0;
      send_msg();
      if (!abort) begin
         for (int n = 0; n < 2000 && !last_seen; n++) tick();
         check("last_seen", 32'(last_seen), 32'd1);
         tick();
      end
   endtask

   task automatic cmp_model(input string name);
      logic [LG-1:0] acc [L];
      logic [LG-1:0] c;
      logic [5:0]    e;
      for (int j = 0; j < L; j++) acc[j] = '0;
      check({name, "_n"}, 32'(outq.size()), 32'(NMSG + L));
      for (int i = 0; i < NMSG; i++) begin
         c = LG'((kv[msg[i]] + i / L) % L);
         acc[i % L] ^= c;
         if (i < outq.size()) check({name, "_ct"}, 32'(outq[i]), 32'({2'b00, c}));
      end
      for (int j = 0; j < L; j++) begin
         e = {1'b1, (j == L - 1), acc[j] ^ LG'(kv[j])};
         if (NMSG + j < outq.size()) check({name, "_tag"}, 32'(outq[NMSG + j]), 32'(e));
      end
   endtask

   initial begin
      logic [5:0] e;
      bit         sr;
      rstn = 1'b0; key_load = 1'b0; key_row = '0; s_valid = 1'b0; s_sym = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_key_ready", 32'(key_ready), 32'd0);
      check("rst_key_err",   32'(key_err),   32'd0);
      check("rst_s_ready",   32'(s_ready),   32'd0);
      check("rst_m_valid",   32'(m_valid),   32'd0);
      check("rst_m_sym",     32'(m_sym),     32'd0);
      check("rst_m_tag",     32'(m_tag),     32'd0);
      check("rst_m_last",    32'(m_last),    32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      rstn = 1'b1;
      tick();

      // Identity key, all-zero message: block b emits b; tag column j = (0^1^..^8) ^ j = 8 ^ j.
      for (int x = 0; x < L; x++) kv[x] = x;
      load_key(1);
      for (int i = 0; i < NMSG; i++) msg[i] = '0;
      run_msg();
      check("id_n", 32'(outq.size()), 32'(NMSG + L));
      for (int i = 0; i < NMSG + L && i < outq.size(); i++) begin
         if (i < NMSG) e = {2'b00, LG'(i / L)};
         else          e = {1'b1, (i == NMSG + L - 1), LG'(8 ^ (i - NMSG))};
         check("id_out", 32'(outq[i]), 32'(e));
      end
      check("id_busy_after", 32'(busy), 32'd0);
      check("id_ready_after", 32'(key_ready), 32'd1);

      // Reversed key under random stalls; block 8: sym 15 -> 0+8 = 8, sym 0 -> 15+8 = 23 -> 7.
      for (int x = 0; x < L; x++) kv[x] = L - 1 - x;
      load_key(1);
      for (int i = 0; i < NMSG; i++) msg[i] = LG'($urandom_range(0, L - 1));
      msg[128] = 4'd15;
      msg[129] = 4'd0;
      rnd_rdy = 1;
      run_msg();
      rnd_rdy = 0;
      check("rev_sym15", 32'(outq[128]), 32'h08);
      check("rev_sym0_wrap", 32'(outq[129]), 32'h07);
      cmp_model("rev");

      // key_load during ENC must be ignored: output still follows the reversed key.
      for (int i = 0; i < NMSG; i++) msg[i] = LG'($urandom_range(0, L - 1));
      fork
         run_msg();
         begin
            for (int n = 0; n < 500; n++) begin
               tick();
               if (s_cnt >= 40) break;
            end
            for (int x = 0; x < L; x++) key_row[x*LG +: LG] = LG'(x);
            key_load = 1'b1;
            tick();
            key_load = 1'b0;
         end
      join
      cmp_model("kl_enc");
      check("kl_enc_ready", 32'(key_ready), 32'd1);

      // All-zero key is not a permutation; encoding must stay blocked.
      for (int x = 0; x < L; x++) kv[x] = 0;
      load_key(0);
      s_valid = 1'b1;
      sr = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         sr |= s_ready;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      check("zk_s_ready", 32'(sr), 32'd0);
      check("zk_busy", 32'(busy), 32'd0);
      check("zk_m_valid", 32'(m_valid), 32'd0);

      // Reset in block 4 of a message, then a fresh key and full message.
      for (int x = 0; x < L; x++) kv[x] = x;
      load_key(1);
      for (int i = 0; i < NMSG; i++) msg[i] = LG'($urandom_range(0, L - 1));
      fork
         run_msg();
         begin
            for (int n = 0; n < 500; n++) begin
               tick();
               if (s_cnt >= 70) break;
            end
            #2;
            rstn  = 1'b0;
            abort = 1;
            #1;
            check("mid_rst_m_valid",   32'(m_valid),   32'd0);
            check("mid_rst_m_sym",     32'(m_sym),     32'd0);
            check("mid_rst_m_tag",     32'(m_tag),     32'd0);
            check("mid_rst_s_ready",   32'(s_ready),   32'd0);
            check("mid_rst_key_ready", 32'(key_ready), 32'd0);
            check("mid_rst_busy",      32'(busy),      32'd0);
         end
      join
      tick();
      rstn  = 1'b1;
      abort = 0;
      tick();
      check("post_rst_key_ready", 32'(key_ready), 32'd0);
      for (int x = 0; x < L; x++) kv[x] = (x * 5 + 3) % L;
      load_key(1);
      for (int i = 0; i < NMSG; i++) msg[i] = LG'($urandom_range(0, L - 1));
      run_msg();
      cmp_model("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/latin_aont_enc.md
# latin_aont_enc

Streaming all-or-nothing encoder for the chaffing-and-winnowing datapath, generalising the fixed 16×16 Latin-square generator to a parametrised, key-validated, handshaked block. A key row (permutation of 0..LSLEN-1) defines the cyclic Latin square L[r][x] = (key[x] + r) mod LSLEN. Each message block is substituted through one row of that square. A final tag block, dependent on every ciphertext symbol, is then appended. It sits between the message packetiser and the chaff/MAC stage.

## Interface
- LSLEN, 16, Latin-square order and symbols per block; power of two, 4..256
- LSLENLOG, 4, log2(LSLEN); symbol width
- NOOFBLOCKS, 9, message blocks per message, 1..LSLEN
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- key_load  in  1  one-cycle pulse; latch key_row, start validation
- key_row  in  LSLEN*LSLENLOG  key; entry x at bits [x*LSLENLOG +: LSLENLOG]
- key_ready  out  1  validated key held; encoding permitted
- key_err  out  1  last loaded key was not a permutation
- s_valid / s_ready  in / out  1  message symbol handshake
- s_sym  in  LSLENLOG  message symbol
- m_valid / m_ready  out / in  1  output symbol handshake
- m_sym  out  LSLENLOG  ciphertext or tag symbol
- m_tag  out  1  m_sym belongs to the tag block
- m_last  out  1  final tag symbol of the message
- busy  out  1  state is CHECK, ENC or TAG

## Operation
- States: IDLE, CHECK, READY, ENC, TAG.
- key_load is honoured only in IDLE or READY; ignored elsewhere.
- On key_load: latch key_row, clear key_ready/key_err, enter CHECK.
- CHECK: one key entry per cycle into a LSLEN-bit seen mask. A duplicate makes the key invalid.
- After LSLEN entries: valid → READY with key_ready=1. Invalid → IDLE with key_err=1.
- READY → ENC on the first s_valid. ENC continues until NOOFBLOCKS*LSLEN symbols are accepted.
- Counters: blk (block index) and col (column, wraps at LSLEN).
- Symbol (blk, col, m) → c = (key[m] + blk) mod LSLEN. The sum is truncated to LSLENLOG bits.
- Accumulator: acc[col] ^= c.
- TAG: emits LSLEN symbols t[j] = acc[j] ^ key[j], j ascending, with m_tag=1. m_last=1 on j=LSLEN-1.
- After the last tag handshake: acc is cleared, counters are reset, state returns to READY.
- s_ready = (state==ENC) && (!m_valid || m_ready).
- The output is a single register stage and holds its value while m_valid && !m_ready.
- Reset values: key_ready=0, key_err=0, s_ready=0, m_valid=0, m_sym=0, m_tag=0, m_last=0, busy=0. State=IDLE, acc and counters = 0, key register = 0.
- Reset mid-message discards everything. A new key_load is required after reset.

## Timing
- key_load sampled at edge T → key_ready or key_err rises at edge T+LSLEN.
- Encode latency: s_valid&&s_ready at edge T → m_valid with c at edge T+1. Full throughput is one symbol per cycle when m_ready=1.
- No combinational path from s_valid to s_ready. m_ready may combinationally affect s_ready.
- First tag symbol: m_valid at the edge after the last ciphertext symbol handshakes; s_ready=0 throughout TAG.
- TAG also sustains one symbol per cycle. After the final tag handshake, READY is entered on the same edge, and s_ready may rise on the following cycle.
- Simultaneous s_valid on the READY→ENC cycle is not accepted; acceptance begins the cycle after entering ENC.

## Structure
- Package ls_pkg holds:
  - LSLEN/LSLENLOG defaults
  - sym_t (logic [LSLENLOG-1:0])
  - state enum ls_state_e {IDLE, CHECK, READY, ENC, TAG}
  - the function ls_entry(key, r, x)
- Sub-module ls_perm_check contains the sequential seen-mask validator (start, entry in, done, ok).
- The top module contains the FSM, counters, accumulator array and output register.

## Test plan
- Identity key (key[x]=x), 144 zeros, m_ready=1 → block b emits 16×b; tag t[j]=8^j; m_last on the 160th output.
- Key all-zeros → key_err=1, key_ready=0 at T+16; s_ready stays 0 when s_valid is driven.
- Reversed key (key[x]=15-x), s_sym=15 in block 8 → c=8; s_sym=0 in block 8 → c=(15+8) mod 16=7 (wrap).
- Random m_ready 50% duty over a random message → output sequence matches the reference model, with no drops or duplicates. m_sym is stable while stalled.
- rstn asserted mid-ENC (block 4) → all outputs 0 immediately. A key_load plus a full message then produces a correct tag (acc cleared).
- key_load pulsed during ENC → ignored; current message tag is unchanged.
